// File: rtl/polar_pkg.sv
// Shared constants, quadrant encoding and the quarter-wave sine coefficient
// generator used by the ROM and by anything that needs a reference value.
package polar_pkg;

  localparam int LUT_BITS  = 10;
  localparam int COEF_BITS = 16;
  localparam int LUT_DEPTH = (1 << LUT_BITS) + 1;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

  // C[i] = round(sin(pi/2 * i / 2^LUT_BITS) * (2^COEF_BITS - 1)); argument is never negative
  function automatic logic [COEF_BITS-1:0] sine_coef(input int i);
    real ang;
    real val;
    ang = 3.14159265358979323846 / 2.0 * real'(i) / real'(1 << LUT_BITS);
    val = $sin(ang) * real'((1 << COEF_BITS) - 1);
    return COEF_BITS'($rtoi(val + 0.5));
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table C[0..2^LUT_BITS] with two independent registered
// read ports sharing one enable; contents are constant and never reset.
module quarter_sine_rom
  import polar_pkg::*;
(
  input  logic                 clk,
  input  logic                 en_i,
  input  logic [LUT_BITS:0]    addr_a_i,
  input  logic [LUT_BITS:0]    addr_b_i,
  output logic [COEF_BITS-1:0] data_a_o,
  output logic [COEF_BITS-1:0] data_b_o
);

  logic [COEF_BITS-1:0] rom [LUT_DEPTH];

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
    assign rom[g] = sine_coef(g);
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      data_a_o <= rom[addr_a_i];
      data_b_o <= rom[addr_b_i];
    end
  end

endmodule

// File: rtl/polar_to_rect.sv
// Polar (unsigned magnitude, phase) to signed I/Q. Fixed pipeline:
// index -> ROM -> multiply -> round -> sign, one sample per clock.
module polar_to_rect #(
  parameter int MAG_BITS      = 17,
  parameter int PHASE_BITS    = 12,
  parameter int LUT_BITS      = PHASE_BITS - 2,
  parameter int COEF_BITS     = 16,
  parameter int DATA_OUT_BITS = MAG_BITS + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            data_in_ready,
  input  logic [MAG_BITS-1:0]             mag_in,
  input  logic [PHASE_BITS-1:0]           phase_in,
  output logic                            data_out_ready,
  output logic signed [DATA_OUT_BITS-1:0] data_out_1,
  output logic signed [DATA_OUT_BITS-1:0] data_out_2
);

  localparam int PW = MAG_BITS + COEF_BITS;
  localparam logic [LUT_BITS:0] IDX_FULL = (LUT_BITS + 1)'(1) << LUT_BITS;
  localparam logic [PW-1:0]     HALF     = PW'(1) << (COEF_BITS - 1);

  // stage 1: indices
  logic                  v1_q;
  logic [MAG_BITS-1:0]   mag1_q;
  polar_pkg::quad_t      quad1_q;
  logic [LUT_BITS:0]     sin_idx1_q, cos_idx1_q;
  // stage 2: coefficients
  logic                  v2_q, cneg2_q, sneg2_q;
  logic [MAG_BITS-1:0]   mag2_q;
  logic [COEF_BITS-1:0]  ccoef2_q, scoef2_q;
  logic [LUT_BITS:0]     addr_cos_d, addr_sin_d;
  // stage 3: products
  logic                  v3_q, cneg3_q, sneg3_q;
  logic [PW-1:0]         pc3_q, ps3_q;
  // stage 4: rounded magnitudes
  logic                  v4_q, cneg4_q, sneg4_q;
  logic [MAG_BITS-1:0]   rc4_q, rs4_q;
  logic [MAG_BITS-1:0]   rc_d, rs_d;
  logic [DATA_OUT_BITS-1:0] out1_d, out2_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q       <= 1'b0;
      mag1_q     <= '0;
      quad1_q    <= polar_pkg::Q0;
      sin_idx1_q <= '0;
      cos_idx1_q <= '0;
    end else begin
      v1_q <= data_in_ready;
      if (data_in_ready) begin
        mag1_q     <= mag_in;
        quad1_q    <= polar_pkg::quad_t'(phase_in[PHASE_BITS-1 -: 2]);
        sin_idx1_q <= {1'b0, phase_in[LUT_BITS-1:0]};
        cos_idx1_q <= IDX_FULL - {1'b0, phase_in[LUT_BITS-1:0]};
      end
    end
  end

  // odd quadrants swap which index feeds cos and sin
  always_comb begin
    addr_cos_d = cos_idx1_q;
    addr_sin_d = sin_idx1_q;
    if (quad1_q == polar_pkg::Q1 || quad1_q == polar_pkg::Q3) begin
      addr_cos_d = sin_idx1_q;
      addr_sin_d = cos_idx1_q;
    end
  end

  quarter_sine_rom u_rom (
    .clk      (clk),
    .en_i     (v1_q),
    .addr_a_i (addr_cos_d),
    .addr_b_i (addr_sin_d),
    .data_a_o (ccoef2_q),
    .data_b_o (scoef2_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q    <= 1'b0;
      mag2_q  <= '0;
      cneg2_q <= 1'b0;
      sneg2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        mag2_q  <= mag1_q;
        cneg2_q <= (quad1_q == polar_pkg::Q1) || (quad1_q == polar_pkg::Q2);
        sneg2_q <= (quad1_q == polar_pkg::Q2) || (quad1_q == polar_pkg::Q3);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3_q    <= 1'b0;
      pc3_q   <= '0;
      ps3_q   <= '0;
      cneg3_q <= 1'b0;
      sneg3_q <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        pc3_q   <= PW'(mag2_q) * PW'(ccoef2_q);
        ps3_q   <= PW'(mag2_q) * PW'(scoef2_q);
        cneg3_q <= cneg2_q;
        sneg3_q <= sneg2_q;
      end
    end
  end

  // product + half LSB stays below 2^PW, so the rounded value fits MAG_BITS
  always_comb begin
    rc_d   = MAG_BITS'((pc3_q + HALF) >> COEF_BITS);
    rs_d   = MAG_BITS'((ps3_q + HALF) >> COEF_BITS);
    out1_d = cneg4_q ? -DATA_OUT_BITS'(rc4_q) : DATA_OUT_BITS'(rc4_q);
    out2_d = sneg4_q ? -DATA_OUT_BITS'(rs4_q) : DATA_OUT_BITS'(rs4_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v4_q    <= 1'b0;
      rc4_q   <= '0;
      rs4_q   <= '0;
      cneg4_q <= 1'b0;
      sneg4_q <= 1'b0;
    end else begin
      v4_q <= v3_q;
      if (v3_q) begin
        rc4_q   <= rc_d;
        rs4_q   <= rs_d;
        cneg4_q <= cneg3_q;
        sneg4_q <= sneg3_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_ready <= 1'b0;
      data_out_1     <= '0;
      data_out_2     <= '0;
    end else begin
      data_out_ready <= v4_q;
      if (v4_q) begin
        data_out_1 <= out1_d;
        data_out_2 <= out2_d;
      end
    end
  end

endmodule

// File: tb/tb_polar_to_rect.sv
// Bench for polar_to_rect: directed axis/diagonal/boundary samples plus a
// randomized stream, all checked against a cycle-indexed reference model.
module tb_polar_to_rect;
  import polar_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                din_v = 1'b0;
  logic [16:0]         mag = '0;
  logic [11:0]         ph = '0;
  logic                dout_v;
  logic signed [17:0]  d1, d2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  polar_to_rect dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_ready  (din_v),
    .mag_in         (mag),
    .phase_in       (ph),
    .data_out_ready (dout_v),
    .data_out_1     (d1),
    .data_out_2     (d2)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // signed sine of a phase, built from quarter-wave symmetry
  function automatic longint csin(input int p);
    int q;
    int k;
    q = (p >> 10) & 3;
    k = p & 1023;
    case (q)
      0:       return  longint'(sine_coef(k));
      1:       return  longint'(sine_coef(1024 - k));
      2:       return -longint'(sine_coef(k));
      default: return -longint'(sine_coef(1024 - k));
    endcase
  endfunction

  function automatic longint proj(input longint m, input longint c);
    longint a;
    longint r;
    a = (c < 0) ? -c : c;
    r = (m * a + 32768) >> 16;
    return (c < 0) ? -r : r;
  endfunction

  function automatic longint ref_i(input longint m, input int p);
    return proj(m, csin((p + 1024) & 4095));
  endfunction

  function automatic longint ref_q(input longint m, input int p);
    return proj(m, csin(p));
  endfunction

  // per-edge record of what the DUT sampled
  bit     hv [8192];
  longint hm [8192];
  int     hp [8192];
  int     edge_cnt = 0;
  int     last_rst_edge = 0;
  bit     mon_en = 1'b0;
  longint exp_i = 0;
  longint exp_q = 0;

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    hv[edge_cnt & 8191] = din_v && rst;
    hm[edge_cnt & 8191] = longint'(mag);
    hp[edge_cnt & 8191] = int'(ph);
  end

  always @(negedge rst) last_rst_edge = edge_cnt;

  always @(negedge clk) begin
    int e;
    bit ev;
    if (mon_en) begin
      e  = edge_cnt - 4;
      ev = 1'b0;
      if (!rst) begin
        exp_i = 0;
        exp_q = 0;
      end else if (e > last_rst_edge && hv[e & 8191]) begin
        ev    = 1'b1;
        exp_i = ref_i(hm[e & 8191], hp[e & 8191]);
        exp_q = ref_q(hm[e & 8191], hp[e & 8191]);
      end
      chk("mon_valid", longint'(dout_v), longint'(ev));
      chk("mon_i", longint'(d1), exp_i);
      chk("mon_q", longint'(d2), exp_q);
    end
  end

  task automatic run_one(input string tag, input logic [16:0] m, input logic [11:0] p,
                         input longint ei, input longint eq);
    int lat;
    lat = 0;
    @(posedge clk);
    #1 din_v = 1'b1; mag = m; ph = p;
    @(posedge clk);
    #1 din_v = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dout_v) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_i"}, longint'(d1), ei);
    chk({tag, "_q"}, longint'(d2), eq);
  endtask

  initial begin
    int sent;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", longint'(dout_v), 0);
    chk("rst_i", longint'(d1), 0);
    chk("rst_q", longint'(d2), 0);
    #2 rst = 1'b1;
    mon_en = 1'b1;

    run_one("ax0",   17'd1000, 12'd0,    1000, 0);
    run_one("ax90",  17'd1000, 12'd1024, 0, 1000);
    run_one("ax180", 17'd1000, 12'd2048, -1000, 0);
    run_one("ax270", 17'd1000, 12'd3072, 0, -1000);
    run_one("d45",   17'd1000, 12'd512,  707, 707);
    run_one("d135",  17'd1000, 12'd1536, -707, 707);
    run_one("full",  17'd131071, 12'd0,  131069, 0);
    run_one("wrap",  17'd50000, 12'd4095, ref_i(50000, 4095), ref_q(50000, 4095));
    for (int i = 0; i < 4; i++) begin
      logic [11:0] rp;
      rp = 12'($urandom);
      run_one("zero", 17'd0, rp, 0, 0);
    end

    run_one("hold", 17'd1000, 12'd1536, -707, 707);
    repeat (20) begin
      @(negedge clk);
      chk("hold_valid", longint'(dout_v), 0);
      chk("hold_i", longint'(d1), -707);
      chk("hold_q", longint'(d2), 707);
    end

    sent = 0;
    while (sent < 256) begin
      @(posedge clk);
      #1;
      din_v = ($urandom_range(0, 3) != 0);
      mag   = 17'($urandom);
      ph    = 12'($urandom);
      case ($urandom_range(0, 7))
        0: mag = 17'h1ffff;
        1: ph  = 12'($urandom_range(0, 3) * 1024);
        default: ;
      endcase
      if (din_v) sent++;
    end
    @(posedge clk);
    #1 din_v = 1'b0;
    repeat (8) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 din_v = 1'b1; mag = 17'($urandom); ph = 12'($urandom);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstb_valid", longint'(dout_v), 0);
    chk("rstb_i", longint'(d1), 0);
    chk("rstb_q", longint'(d2), 0);
    @(negedge clk);
    #2 rst = 1'b1; din_v = 1'b0;
    run_one("post_rst", 17'd1000, 12'd1024, 0, 1000);

    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/polar_to_rect.md
Name: polar_to_rect

Overview:
- Inverse of the magnitude path: converts a polar sample (unsigned magnitude, unsigned phase) into signed rectangular I/Q.
- Sits upstream of any block that consumes I/Q pairs. Used to regenerate test tones and to re-synthesise signals after magnitude/phase processing.
- Fully pipelined. One sample per clock, fixed latency, no backpressure. Same `data_in_ready`/`data_out_ready` valid-strobe convention as the square-sum and square-root blocks.

Parameters:
- `MAG_BITS`, 17: unsigned magnitude input width. Matches the magnitude block output.
- `PHASE_BITS`, 12: unsigned phase width. A full circle is 2^`PHASE_BITS` counts.
- `LUT_BITS`, `PHASE_BITS`-2 (10): quarter-wave index width. Must equal `PHASE_BITS`-2.
- `COEF_BITS`, 16: unsigned sine coefficient width.
- `DATA_OUT_BITS`, `MAG_BITS`+1 (18): signed two's-complement I/Q width.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `data_in_ready`, input, 1: input sample valid strobe.
- `mag_in`, input, `MAG_BITS`: unsigned magnitude.
- `phase_in`, input, `PHASE_BITS`: unsigned phase, 0 = 0 rad.
- `data_out_ready`, output, 1: output sample valid strobe.
- `data_out_1`, output, `DATA_OUT_BITS`: signed I = mag·cos(phase).
- `data_out_2`, output, `DATA_OUT_BITS`: signed Q = mag·sin(phase).

Behaviour:
- Reset (`rst` low, asynchronous assertion):
  - All stage valid flags clear; `data_out_ready` = 0, `data_out_1` = 0, `data_out_2` = 0.
  - In-flight samples are dropped, never emitted.
  - Deassertion is synchronous to `clk` at the use site.
- Latency: exactly 4 cycles. A sample accepted on edge N (`data_in_ready` = 1) appears with `data_out_ready` = 1 after edge N+4.
- Throughput: one sample per cycle, back-to-back with no bubbles. Valid flag pattern is preserved exactly.
- Hold rule: each stage's data registers load only when that stage's incoming valid is 1, otherwise hold. `data_out_*` hold their last value while `data_out_ready` = 0.
- Stage 1 (register):
  - quad = `phase_in`[top 2 bits], k = `phase_in`[`LUT_BITS`-1:0].
  - Register mag, quad, sin_idx = k, cos_idx = 2^`LUT_BITS` - k (range 1..1024). Index width is `LUT_BITS`+1.
- Stage 2 (ROM):
  - Registered dual read of the quarter-wave ROM C[0..2^`LUT_BITS`].
  - C[i] = round(sin(π/2·i/2^`LUT_BITS`)·(2^`COEF_BITS`-1)). C[0] = 0, C[1024] = 65535, C[512] = 46340.
  - Compute signs by quadrant:
    - q0: cos = +C[cos_idx], sin = +C[sin_idx]
    - q1: cos = -C[sin_idx], sin = +C[cos_idx]
    - q2: cos = -C[cos_idx], sin = -C[sin_idx]
    - q3: cos = +C[sin_idx], sin = -C[cos_idx]
- Stage 3 (multiply): unsigned products mag·|cos| and mag·|sin|, each `MAG_BITS`+`COEF_BITS` bits. Sign bits pipelined alongside.
- Stage 4 (round and sign):
  - r = (p + 2^(`COEF_BITS`-1)) >> `COEF_BITS`; r < 2^`MAG_BITS` always, so no saturation is needed.
  - Output = sign ? -r : r, zero-extended to `DATA_OUT_BITS` before negation.
  - A zero result with the negative sign yields 0, never -0 encoding issues.
- Boundaries:
  - Phase wraps naturally: max phase 4095 maps to q3, k = 1023.
  - `mag_in` = 0 gives 0/0 at any phase.
  - Exact quadrant boundaries (k = 0) must hit C[0]/C[1024] exactly.
  - Reset during a burst: outputs go to 0 immediately. The first post-reset output is the 4-cycle-delayed first new input.

Decomposition:
- Package `polar_pkg`:
  - Constants `LUT_BITS`, `COEF_BITS`, `LUT_DEPTH` = 2^`LUT_BITS`+1.
  - typedef enum quad_t {Q0, Q1, Q2, Q3}.
  - Function `sine_coef(i)` used for ROM initialisation and by the bench model.
- Sub-module `quarter_sine_rom`: two registered read ports, initialised from `sine_coef`, no reset on its contents.

Test Plan:
- Axes: mag=1000 at phase 0, 1024, 2048, 3072 → (I,Q) = (1000,0), (0,1000), (-1000,0), (0,-1000), each 4 cycles after its strobe.
- 45°: mag=1000, phase=512 → (707,707). Phase=1536 → (-707,707).
- Full scale and zero: mag=131071, phase=0 → (131069,0). mag=0 at random phases → (0,0).
- Streaming: 256 back-to-back samples with random mag/phase and random strobe gaps → outputs match the `sine_coef` reference model bit-exactly, and the `data_out_ready` pattern equals the input pattern delayed by 4.
- Reset: assert `rst` low mid-burst for 1 cycle → `data_out_ready` = 0 and outputs = 0 immediately. No stale sample emerges. A new sample at release+1 appears 4 cycles later.
- Hold: a single strobe followed by 20 idle cycles → `data_out_1`/`data_out_2` stay constant with `data_out_ready` = 0 after the one valid cycle.
